// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared state encoding and default widths for the DM arbiter
package dm_arbiter_pkg;

   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_MAX_WAIT = 4;
   localparam int WAIT_CNT_W   = 4;   // holds MAX_WAIT up to 15

   // Records whether a read was issued last cycle and which port owns the return
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PIPE_RD = 2'd1,
      LOAD_RD = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// rtl/dm_arb_starve_cnt.sv - loader starvation counter with saturation compare
import dm_arbiter_pkg::*;

module dm_arb_starve_cnt #(
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  l_req,
   input  logic                  l_grant,
   output logic [WAIT_CNT_W-1:0] wait_cnt,
   output logic                  starve
);

   // Count cycles the loader waits; any grant or dropped request restarts the count
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!l_req || l_grant) begin
         wait_cnt <= '0;
      end else if (!starve) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Reaching the limit forces the loader through on the current cycle
   always_comb begin
      starve = (wait_cnt == WAIT_CNT_W'(MAX_WAIT));
   end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data-memory arbiter, pipeline priority with loader anti-starvation
import dm_arbiter_pkg::*;

module dm_arbiter #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_rw,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_stall,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_rvalid,
   input  logic              l_req,
   input  logic              l_rw,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_ack,
   output logic [DATA_W-1:0] l_rdata,
   output logic              l_rvalid,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e                state, state_next;
   logic                      p_grant, l_grant;
   logic                      starve;
   logic [WAIT_CNT_W-1:0]     wait_cnt;
   logic [DATA_W-1:0]         p_hold, l_hold;

   dm_arb_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk      (clk),
      .reset    (reset),
      .l_req    (l_req),
      .l_grant  (l_grant),
      .wait_cnt (wait_cnt),
      .starve   (starve)
   );

   // State register: remembers which port's read returns next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant decision and memory command mux; everything held at zero during reset
   always_comb begin
      state_next = IDLE;
      p_grant    = 1'b0;
      l_grant    = 1'b0;
      p_stall    = 1'b0;
      l_ack      = 1'b0;
      mem_en     = 1'b0;
      mem_rw     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (!reset) begin
         if (l_req && (starve || !p_req)) begin
            l_grant = 1'b1;
         end else if (p_req) begin
            p_grant = 1'b1;
         end
         p_stall = p_req && !p_grant;
         l_ack   = l_grant;
         if (p_grant) begin
            mem_en     = 1'b1;
            mem_rw     = p_rw;
            mem_addr   = p_addr;
            mem_wdata  = p_wdata;
            state_next = p_rw ? IDLE : PIPE_RD;
         end else if (l_grant) begin
            mem_en     = 1'b1;
            mem_rw     = l_rw;
            mem_addr   = l_addr;
            mem_wdata  = l_wdata;
            state_next = l_rw ? IDLE : LOAD_RD;
         end
      end
   end

   // Route the returning read data to its owner; other port keeps its last value
   always_comb begin
      p_rvalid = !reset && (state == PIPE_RD);
      l_rvalid = !reset && (state == LOAD_RD);
      p_rdata  = '0;
      l_rdata  = '0;
      if (!reset) begin
         p_rdata = p_rvalid ? mem_rdata : p_hold;
         l_rdata = l_rvalid ? mem_rdata : l_hold;
      end
   end

   // Capture delivered read data so rdata holds between pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         p_hold <= '0;
         l_hold <= '0;
      end else begin
         if (p_rvalid) p_hold <= mem_rdata;
         if (l_rvalid) l_hold <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed scoreboard bench for dm_arbiter
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_req, p_rw, l_req, l_rw;
   logic [15:0] p_addr, p_wdata, l_addr, l_wdata;
   logic        p_stall, p_rvalid, l_ack, l_rvalid;
   logic [15:0] p_rdata, l_rdata;
   logic        mem_en, mem_rw;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   typedef struct {
      logic        owner_l;
      logic [15:0] data;
   } ret_t;

   ret_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] planned_rd, last_p, last_l;

   dm_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .p_req     (p_req),
      .p_rw      (p_rw),
      .p_addr    (p_addr),
      .p_wdata   (p_wdata),
      .p_stall   (p_stall),
      .p_rdata   (p_rdata),
      .p_rvalid  (p_rvalid),
      .l_req     (l_req),
      .l_rw      (l_rw),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .l_ack     (l_ack),
      .l_rdata   (l_rdata),
      .l_rvalid  (l_rvalid),
      .mem_en    (mem_en),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; memory returns the data planned during the previous cycle
   task automatic tick();
      @(posedge clk);
      #1;
      mem_rdata  = planned_rd;
      planned_rd = 16'($urandom);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".p_stall"},  p_stall,  0);
      chk({tag, ".l_ack"},    l_ack,    0);
      chk({tag, ".mem_en"},   mem_en,   0);
      chk({tag, ".p_rvalid"}, p_rvalid, 0);
      chk({tag, ".l_rvalid"}, l_rvalid, 0);
      chk({tag, ".p_rdata"},  p_rdata,  0);
      chk({tag, ".l_rdata"},  l_rdata,  0);
   endtask

   task automatic check_ret(input string tag);
      ret_t        e;
      logic        ep = 1'b0;
      logic        el = 1'b0;
      logic [15:0] d  = '0;
      if (sb.size() > 0) begin
         e  = sb.pop_front();
         ep = !e.owner_l;
         el = e.owner_l;
         d  = e.data;
      end
      chk({tag, ".p_rvalid"}, p_rvalid, ep);
      chk({tag, ".l_rvalid"}, l_rvalid, el);
      if (ep) last_p = d;
      if (el) last_l = d;
      chk({tag, ".p_rdata"}, p_rdata, last_p);
      chk({tag, ".l_rdata"}, l_rdata, last_l);
   endtask

   task automatic check_grant(input string tag, input logic eg_p, input logic eg_l);
      ret_t e;
      chk({tag, ".l_ack"},   l_ack,   eg_l);
      chk({tag, ".p_stall"}, p_stall, p_req & ~eg_p);
      chk({tag, ".mem_en"},  mem_en,  eg_p | eg_l);
      if (eg_p) begin
         chk({tag, ".mem_rw"},   mem_rw,   p_rw);
         chk({tag, ".mem_addr"}, mem_addr, p_addr);
         if (p_rw) chk({tag, ".mem_wdata"}, mem_wdata, p_wdata);
         else begin
            e.owner_l = 1'b0; e.data = planned_rd; sb.push_back(e);
         end
      end
      if (eg_l) begin
         chk({tag, ".mem_rw"},   mem_rw,   l_rw);
         chk({tag, ".mem_addr"}, mem_addr, l_addr);
         if (l_rw) chk({tag, ".mem_wdata"}, mem_wdata, l_wdata);
         else begin
            e.owner_l = 1'b1; e.data = planned_rd; sb.push_back(e);
         end
      end
   endtask

   task automatic cyc(input string tag, input logic eg_p, input logic eg_l);
      #1;
      check_ret(tag);
      check_grant(tag, eg_p, eg_l);
   endtask

   initial begin
      reset = 1'b1;
      p_req = 1'b1; p_rw = 1'b0; p_addr = '0; p_wdata = '0;
      l_req = 1'b1; l_rw = 1'b0; l_addr = '0; l_wdata = '0;
      mem_rdata = '0; planned_rd = '0; last_p = '0; last_l = '0;

      // Reset held two cycles with both ports requesting
      for (int i = 0; i < 2; i++) begin
         tick();
         #1;
         chk_zero("reset");
      end

      tick();
      reset = 1'b0; p_req = 1'b0; l_req = 1'b0;
      cyc("idle0", 0, 0);

      // Pipeline read of 0x0003 returning 0xFFFF
      tick();
      p_req = 1'b1; p_rw = 1'b0; p_addr = 16'h0003; planned_rd = 16'hFFFF;
      cyc("p_rd", 1, 0);
      tick();
      p_req = 1'b0;
      cyc("p_rd_ret", 0, 0);

      // Loader write with pipeline idle
      tick();
      l_req = 1'b1; l_rw = 1'b1; l_addr = 16'h0010; l_wdata = 16'hABCD;
      cyc("l_wr", 0, 1);
      tick();
      l_req = 1'b0;
      cyc("l_wr_after", 0, 0);

      // Both ports request continuously: four pipeline grants, then the loader
      for (int i = 0; i < 4; i++) begin
         tick();
         p_req = 1'b1; p_rw = 1'b0; p_addr = 16'h0100 + 16'(i);
         l_req = 1'b1; l_rw = 1'b1; l_addr = 16'h0020; l_wdata = 16'h5A5A;
         chk("starve.wait_cnt", dut.u_starve.wait_cnt, i);
         cyc("starve_p", 1, 0);
      end
      tick();
      cyc("starve_l", 0, 1);
      chk("starve_l.p_stall_hi", p_stall, 1);
      tick();
      cyc("starve_resume", 1, 0);
      tick();
      p_req = 1'b0; l_req = 1'b0;
      cyc("starve_idle", 0, 0);

      // Alternating reads P, L, P
      tick();
      p_req = 1'b1; p_rw = 1'b0; p_addr = 16'h0040;
      cyc("alt_p0", 1, 0);
      tick();
      p_req = 1'b0; l_req = 1'b1; l_rw = 1'b0; l_addr = 16'h0041;
      cyc("alt_l", 0, 1);
      tick();
      l_req = 1'b0; p_req = 1'b1; p_rw = 1'b0; p_addr = 16'h0042;
      cyc("alt_p1", 1, 0);
      tick();
      p_req = 1'b0;
      cyc("alt_end", 0, 0);

      // Loader read followed immediately by reset: return is discarded
      tick();
      l_req = 1'b1; l_rw = 1'b0; l_addr = 16'h0050;
      cyc("l_rd_pre_rst", 0, 1);
      tick();
      reset = 1'b1; l_req = 1'b0;
      sb.delete(); last_p = '0; last_l = '0;
      #1;
      chk_zero("rst_discard");
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst.wait_cnt", dut.u_starve.wait_cnt, 0);
      cyc("post_rst", 0, 0);

      chk("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory word-address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter MAX_WAIT, default 4, loader starvation limit in cycles (range 1..15).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 p_req  in  1  pipeline (DM-stage) access request.
REQ-007 p_rw  in  1  pipeline direction: 1 = write, 0 = read.
REQ-008 p_addr  in  ADDR_W  pipeline address.
REQ-009 p_wdata  in  DATA_W  pipeline write data.
REQ-010 p_stall  out  1  pipeline request not accepted this cycle; hold inputs.
REQ-011 p_rdata  out  DATA_W  pipeline read data.
REQ-012 p_rvalid  out  1  p_rdata valid (1-cycle pulse).
REQ-013 l_req, l_rw, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader/debug port, same meaning as the p_* inputs.
REQ-014 l_ack  out  1  loader request accepted this cycle.
REQ-015 l_rdata  out  DATA_W; l_rvalid  out  1  loader read return.
REQ-016 mem_en, mem_rw  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  data-memory command.
REQ-017 mem_rdata  in  DATA_W  memory read data, valid the cycle after the read command.

Function
REQ-018 At most one memory command per cycle; mem_en=1 only in a cycle where exactly one port is granted.
REQ-019 Grant is combinational from the current requests and registered state; the granted port's rw/addr/wdata are driven to mem_* in the same cycle.
REQ-020 Default priority: pipeline over loader.
REQ-021 Starvation counter wait_cnt increments each cycle l_req=1 and loader not granted; clears on loader grant or l_req=0.
REQ-022 When wait_cnt = MAX_WAIT, the loader is granted regardless of p_req; p_stall=1 that cycle.
REQ-023 p_stall = p_req and not pipeline-granted; p_stall=0 when p_req=0.
REQ-024 l_ack = 1 exactly in loader-granted cycles.
REQ-025 Read return: for a read granted in cycle N, mem_rdata in cycle N+1 is routed to the owner's rdata and its rvalid pulses in N+1; the other port's rvalid stays 0.
REQ-026 Writes produce no rvalid; write latency is 0 from the grant (committed at the grant edge).
REQ-027 Back-to-back grants allowed every cycle, including alternating owners; a read return in N+1 and a new grant in N+1 coexist.
REQ-028 Registered state: {IDLE, PIPE_RD, LOAD_RD}, recording whether a read was issued last cycle and by whom; IDLE after writes or no grant.
REQ-029 rdata outputs hold their last value when rvalid=0.
REQ-030 Simultaneous p_req and l_req with wait_cnt < MAX_WAIT: pipeline granted, wait_cnt increments.

Reset
REQ-031 While reset=1: state=IDLE, wait_cnt=0, all outputs 0 (including p_stall, l_ack, mem_en, rdata, rvalid).
REQ-032 Reset asserted in the cycle after a read grant discards that return; no rvalid pulse follows reset.

Structure
REQ-033 A shared package holds the state encoding (2-bit IDLE=0, PIPE_RD=1, LOAD_RD=2) and the default widths.
REQ-034 One sub-module, dm_arb_starve_cnt, implements wait_cnt and its saturation compare; the rest is flat.

Verification
REQ-035 Reset: hold reset 2 cycles with p_req=l_req=1 -> all outputs 0, no mem_en.
REQ-036 Pipeline read of addr 0x0003 (mem_rdata=0xFFFF next cycle) -> mem_en=1, mem_rw=0 in cycle N; p_rvalid=1 with p_rdata=0xFFFF in N+1; p_stall=0.
REQ-037 Loader write 0x0010 := 0xABCD with p_req=0 -> l_ack=1, mem_rw=1, mem_wdata=0xABCD in the same cycle; no rvalid.
REQ-038 Both ports request continuously, MAX_WAIT=4 -> pipeline granted 4 cycles, loader granted in the 5th with p_stall=1, then the pipeline resumes.
REQ-039 Alternating reads P, L, P on consecutive cycles -> rvalid pulses on p, l, p in consecutive cycles with matching data.
REQ-040 Loader read granted, reset asserted next cycle -> l_rvalid stays 0 and wait_cnt=0 after reset.
